// File: rtl/term_out_pkg.sv
// Shared types and constants for the terminal character-output stage.
// TERM_OUT_FILTER_EN selects the optional control-character input filter.
package term_pkg;

    localparam int CHAR_W = 7;

    localparam logic [CHAR_W-1:0] ASCII_CR    = 7'h0D;
    localparam logic [CHAR_W-1:0] ASCII_DEL   = 7'h7F;
    localparam logic [CHAR_W-1:0] ASCII_SPACE = 7'h20;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } term_state_t;

    // CR survives the filter; other controls and DEL do not
    function automatic logic char_allowed(input logic [CHAR_W-1:0] c);
        return !(((c < ASCII_SPACE) && (c != ASCII_CR)) || (c == ASCII_DEL));
    endfunction

endpackage

// File: rtl/term_out_char_fifo.sv
// Small synchronous character FIFO with combinational head output.
// Pointers wrap naturally because DEPTH is a power of two.
module char_fifo #(
    parameter int DEPTH  = 8,
    parameter int CHAR_W = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [CHAR_W-1:0]          din,
    output logic [CHAR_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CHAR_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/term_out.sv
// Terminal output stage: buffers CPU characters and replays them as paced strobes.
// Define TERM_OUT_FILTER_EN to drop control characters (except CR) and DEL.
module term_out
    import term_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int STB_HOLD = 4,
    parameter int STB_GAP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              wr_stb,
    output logic              busy,
    output logic              ovf,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_stb
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int TMAX = (STB_HOLD > STB_GAP) ? STB_HOLD : STB_GAP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] HOLD_LD = TW'(STB_HOLD - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(STB_GAP - 1);

    term_state_t       r_state;
    term_state_t       w_state_nxt;
    logic [TW-1:0]     r_timer;
    logic [TW-1:0]     w_timer_nxt;
    logic [CHAR_W-1:0] r_char;
    logic [CHAR_W-1:0] w_char_nxt;
    logic              r_stb;
    logic              w_stb_nxt;
    logic              r_ovf;

    logic              w_keep;
    logic              w_push;
    logic              w_pop;
    logic [CHAR_W-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;

`ifdef TERM_OUT_FILTER_EN
    assign w_keep = char_allowed(wr_data);
`else
    assign w_keep = 1'b1;
`endif

    // Fullness is judged on the registered count, so a same-cycle pop never helps
    assign busy   = (w_count == CW'(DEPTH));
    assign w_push = wr_stb && w_keep && !busy;

    char_fifo #(
        .DEPTH  (DEPTH),
        .CHAR_W (CHAR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_char_nxt  = r_char;
        w_stb_nxt   = r_stb;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_char_nxt  = w_head;
                    w_stb_nxt   = 1'b1;
                    w_timer_nxt = HOLD_LD;
                    w_state_nxt = STROBE;
                end
            end
            STROBE: begin
                if (r_timer == '0) begin
                    w_stb_nxt   = 1'b0;
                    w_timer_nxt = GAP_LD;
                    w_state_nxt = GAP;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            GAP: begin
                if (r_timer == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_stb_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_char  <= '0;
            r_stb   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_char  <= w_char_nxt;
            r_stb   <= w_stb_nxt;
            r_ovf   <= r_ovf | (wr_stb && w_keep && w_full);
        end
    end

    assign ovf      = r_ovf;
    assign out_char = r_char;
    assign out_stb  = r_stb;

endmodule

// File: tb/tb_term_out.sv
// Randomized and directed checks of term_out against a queue-and-timestamp model.
module tb_term_out;

    localparam int DEPTH = 8;
    localparam int HOLD  = 4;
    localparam int GAP   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] wr_data = '0;
    logic       wr_stb = 1'b0;
    logic       busy;
    logic       ovf;
    logic [6:0] out_char;
    logic       out_stb;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queued characters plus the cycle stamps of the current strobe slot
    logic [6:0] mq[$];
    logic [6:0] m_char;
    int         m_stb_end;
    int         m_free;
    bit         m_ovf;
    int         cyc = 0;

    int         rise_cyc[$];
    logic [6:0] rise_chr[$];
    logic       prev_stb = 1'b0;

    term_out #(
        .DEPTH    (DEPTH),
        .STB_HOLD (HOLD),
        .STB_GAP  (GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_stb   (wr_stb),
        .busy     (busy),
        .ovf      (ovf),
        .out_char (out_char),
        .out_stb  (out_stb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_char    = '0;
        m_stb_end = 0;
        m_free    = 0;
        m_ovf     = 1'b0;
    endtask

    function automatic bit accepted(input logic [6:0] c);
        bit k;
`ifdef TERM_OUT_FILTER_EN
        k = !(((c < 7'h20) && (c != 7'h0D)) || (c == 7'h7F));
`else
        k = (c <= 7'h7F);
`endif
        return k;
    endfunction

    // Per-edge model update and compare
    initial begin
        model_reset();
        forever begin
            bit was_full;
            @(posedge clk);
            cyc++;
            if (rst_n) begin
                was_full = (mq.size() == DEPTH);
                if (mq.size() > 0 && cyc >= m_free) begin
                    m_char    = mq.pop_front();
                    m_stb_end = cyc + HOLD;
                    m_free    = cyc + HOLD + GAP + 1;
                end
                if (wr_stb && accepted(wr_data)) begin
                    if (was_full) m_ovf = 1'b1;
                    else mq.push_back(wr_data);
                end
            end
            #1;
            check("out_stb", 32'(out_stb), 32'(cyc < m_stb_end));
            check("out_char", 32'(out_char), 32'(m_char));
            check("busy", 32'(busy), 32'(mq.size() == DEPTH));
            check("ovf", 32'(ovf), 32'(m_ovf));
            if (out_stb && !prev_stb) begin
                rise_cyc.push_back(cyc);
                rise_chr.push_back(out_char);
            end
            prev_stb = out_stb;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        wr_stb = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_seq(input logic [6:0] seq[$]);
        foreach (seq[i]) begin
            @(negedge clk);
            wr_data = seq[i];
            wr_stb  = 1'b1;
        end
        @(negedge clk);
        wr_stb = 1'b0;
    endtask

    task automatic check_rises(input string name, input logic [6:0] exp[$]);
        check({name, "_n"}, 32'(rise_chr.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < rise_chr.size())
                check({name, "_chr"}, 32'(rise_chr[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [6:0] seq[$];
        logic [6:0] exp[$];
        bit         exp1[6];
        bit         seen;

        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_char", 32'(out_char), 32'h00);
        check("rst_stb", 32'(out_stb), 32'd0);

        // Single write: popped one edge after acceptance, high for 4 edges
        exp1 = '{1, 1, 1, 1, 0, 0};
        @(negedge clk);
        wr_data = 7'h41;
        wr_stb  = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
        check("t1_stb_accept", 32'(out_stb), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #2;
            check("t1_stb", 32'(out_stb), 32'(exp1[k]));
            if (exp1[k]) check("t1_char", 32'(out_char), 32'h41);
        end
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_ovf", 32'(ovf), 32'd0);
        repeat (6) @(negedge clk);

        // Back-to-back A,B,C
        rise_cyc.delete();
        rise_chr.delete();
        seq = '{7'h41, 7'h42, 7'h43};
        write_seq(seq);
        repeat (30) @(negedge clk);
        check_rises("t2", seq);
        if (rise_cyc.size() == 3) begin
            check("t2_gap1", 32'(rise_cyc[1] - rise_cyc[0]), 32'd9);
            check("t2_gap2", 32'(rise_cyc[2] - rise_cyc[1]), 32'd9);
        end

        // Nine writes fill the FIFO; a later write on the popping edge is dropped
        do_reset();
        rise_cyc.delete();
        rise_chr.delete();
        seq.delete();
        for (int i = 0; i < 9; i++) seq.push_back(7'(7'h61 + i));
        foreach (seq[i]) begin
            @(negedge clk);
            wr_data = seq[i];
            wr_stb  = 1'b1;
        end
        @(negedge clk);
        wr_stb = 1'b0;
        check("t3_busy_full", 32'(busy), 32'd1);
        check("t3_ovf_clear", 32'(ovf), 32'd0);
        @(negedge clk);
        wr_data = 7'h7A;
        wr_stb  = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
        check("t4_ovf_set", 32'(ovf), 32'd1);
        check("t4_busy_after_pop", 32'(busy), 32'd0);
        repeat (90) @(negedge clk);
        check_rises("t3", seq);
        check("t3_ovf_sticky", 32'(ovf), 32'd1);

        // Reset mid-strobe with three characters queued
        do_reset();
        seq = '{7'h31, 7'h32, 7'h33, 7'h34};
        write_seq(seq);
        check("t5_stb_before", 32'(out_stb), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_stb_async", 32'(out_stb), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rise_cyc.delete();
        rise_chr.delete();
        repeat (25) @(negedge clk);
        check("t5_no_strobe", 32'(rise_chr.size()), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);

        // Control-character filter
        rise_cyc.delete();
        rise_chr.delete();
        seq = '{7'h07, 7'h0D, 7'h7F, 7'h5A};
`ifdef TERM_OUT_FILTER_EN
        exp = '{7'h0D, 7'h5A};
`else
        exp = '{7'h07, 7'h0D, 7'h7F, 7'h5A};
`endif
        write_seq(seq);
        repeat (45) @(negedge clk);
        check_rises("t6", exp);

        // Bounded wait for an out_stb rise after a fresh write
        seen = 1'b0;
        @(negedge clk);
        wr_data = 7'h55;
        wr_stb  = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (out_stb) seen = 1'b1;
        end
        check("t7_strobe_seen", 32'(seen), 32'd1);
        repeat (10) @(negedge clk);

        // Randomized traffic in bursty and sparse phases, one async reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = ((i / 300) % 2 == 0) ? 85 : 12;
            @(negedge clk);
            wr_stb  = ($urandom_range(99) < dens);
            wr_data = 7'($urandom);
            if (i == 1777) begin
                #3;
                rst_n = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        wr_stb = 1'b0;
        repeat (100) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
